// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: data-memory wait handling with timeout, branch flush and load-use bubbles.
// Optional stall performance counter (stallCount port) enabled by defining STALL_PERF_COUNTER_EN.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_memReadEnable,
    input  logic        MEM_memWriteEnable,
    input  logic        dmem_ready,
    input  logic        loadUse_I,
    input  logic        branch_I,
    output logic        dmem_req,
    output logic        IF_pcWriteEnable,
    output logic        IF_ID_enable,
    output logic        ID_EX_enable,
    output logic        EX_MEM_enable,
    output logic        MEM_WB_enable,
    output logic        ID_bubbleSelect,
    output logic        EX_bubbleSelect,
    output logic        WB_bubbleSelect,
    output logic        IF_flush,
    output logic        memError
`ifdef STALL_PERF_COUNTER_EN
    ,
    output logic [31:0] stallCount
`endif
);

    // state | meaning
    // IDLE  | no outstanding access; zero-wait accesses complete here
    // WAIT  | access outstanding, pipeline frozen until dmem_ready
    // ERROR | memory timed out; pipeline frozen until rst
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

    state_t     state, nextState;
    logic [7:0] waitCount, nextWaitCount;
    logic       memAccess;
    logic       memStall;
    logic       loadUseStall;
    logic       inError;

    assign memAccess = MEM_memReadEnable | MEM_memWriteEnable;
    assign inError   = (state == ERROR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            waitCount <= 8'd0;
            memError  <= 1'b0;
        end else begin
            state     <= nextState;
            waitCount <= nextWaitCount;
            memError  <= memError | (nextState == ERROR);
        end
    end

    always_comb begin
        nextState     = state;
        nextWaitCount = waitCount;
        memStall      = 1'b0;
        dmem_req      = 1'b0;
        case (state)
            IDLE: begin
                if (memAccess) begin
                    dmem_req = 1'b1;
                    if (!dmem_ready) begin
                        memStall      = 1'b1;
                        nextState     = WAIT;
                        nextWaitCount = 8'd1;
                    end
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    nextState     = IDLE;
                    nextWaitCount = 8'd0;
                end else begin
                    memStall = 1'b1;
                    if (waitCount == TIMEOUT_VAL) begin
                        nextState = ERROR;
                    end else if (waitCount != 8'hFF) begin
                        nextWaitCount = waitCount + 8'd1;
                    end
                end
            end
            ERROR: begin
                nextState = ERROR;
            end
            default: begin
                nextState     = IDLE;
                nextWaitCount = 8'd0;
            end
        endcase
    end

    // Priority: memory stall, then branch flush, then load-use bubble.
    always_comb begin
        IF_pcWriteEnable = 1'b1;
        IF_ID_enable     = 1'b1;
        ID_EX_enable     = 1'b1;
        EX_MEM_enable    = 1'b1;
        MEM_WB_enable    = 1'b1;
        ID_bubbleSelect  = 1'b0;
        EX_bubbleSelect  = 1'b0;
        WB_bubbleSelect  = 1'b0;
        IF_flush         = 1'b0;
        loadUseStall     = 1'b0;
        if (inError) begin
            IF_pcWriteEnable = 1'b0;
            IF_ID_enable     = 1'b0;
            ID_EX_enable     = 1'b0;
            EX_MEM_enable    = 1'b0;
            MEM_WB_enable    = 1'b0;
        end else if (memStall) begin
            IF_pcWriteEnable = 1'b0;
            IF_ID_enable     = 1'b0;
            ID_EX_enable     = 1'b0;
            EX_MEM_enable    = 1'b0;
            MEM_WB_enable    = 1'b0;
            WB_bubbleSelect  = 1'b1;
        end else if (branch_I) begin
            IF_flush         = 1'b1;
            ID_bubbleSelect  = 1'b1;
            EX_bubbleSelect  = 1'b1;
        end else if (loadUse_I) begin
            IF_pcWriteEnable = 1'b0;
            IF_ID_enable     = 1'b0;
            ID_EX_enable     = 1'b0;
            ID_bubbleSelect  = 1'b1;
            loadUseStall     = 1'b1;
        end
    end

`ifdef STALL_PERF_COUNTER_EN
    // Both stall sources are already forced low in ERROR, so no extra gating here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount <= 32'd0;
        end else if (memStall || loadUseStall) begin
            stallCount <= stallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed literal checks plus randomized run against a behavioural model.
module tb_pipeline_stall_controller;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdEn = 1'b0, wrEn = 1'b0, rdy = 1'b0, lu = 1'b0, br = 1'b0;
    logic dmem_req, pcWe, ifId, idEx, exMem, memWb, idB, exB, wbB, flush, memError;
`ifdef STALL_PERF_COUNTER_EN
    logic [31:0] stallCount;
`endif

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .MEM_memReadEnable(rdEn), .MEM_memWriteEnable(wrEn),
        .dmem_ready(rdy), .loadUse_I(lu), .branch_I(br),
        .dmem_req(dmem_req),
        .IF_pcWriteEnable(pcWe), .IF_ID_enable(ifId), .ID_EX_enable(idEx),
        .EX_MEM_enable(exMem), .MEM_WB_enable(memWb),
        .ID_bubbleSelect(idB), .EX_bubbleSelect(exB), .WB_bubbleSelect(wbB),
        .IF_flush(flush), .memError(memError)
`ifdef STALL_PERF_COUNTER_EN
        , .stallCount(stallCount)
`endif
    );

    // {req, pc, ifid, idex, exmem, memwb, idB, exB, wbB, flush, err}
    wire logic [10:0] dutVec = {dmem_req, pcWe, ifId, idEx, exMem, memWb, idB, exB, wbB, flush, memError};

    localparam logic [10:0] V_IDLE  = 11'b0_11111_000_0_0;
    localparam logic [10:0] V_ACC   = 11'b1_11111_000_0_0;
    localparam logic [10:0] V_STALL = 11'b1_00000_001_0_0;
    localparam logic [10:0] V_BR    = 11'b0_11111_110_1_0;
    localparam logic [10:0] V_LU    = 11'b0_00011_100_0_0;
    localparam logic [10:0] V_ERR   = 11'b0_00000_000_0_1;

    int total = 0;
    int bad = 0;

    // Model: error flag, number of wait cycles already spent on the outstanding access (0 = none), stall tally.
    bit          mErr = 1'b0;
    int          mWait = 0;
    logic [31:0] mCnt = 32'd0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [10:0] modelVec(input logic r, input logic w, input logic rd, input logic l, input logic b);
        logic       req;
        logic [4:0] en;
        logic       ib, eb, wb, fl;
        if (mErr) return V_ERR;
        req = (mWait > 0) || r || w;
        en = 5'b11111;
        ib = 1'b0; eb = 1'b0; wb = 1'b0; fl = 1'b0;
        if (req && !rd) begin
            en = 5'b00000; wb = 1'b1;
        end else if (b) begin
            ib = 1'b1; eb = 1'b1; fl = 1'b1;
        end else if (l) begin
            en = 5'b00011; ib = 1'b1;
        end
        return {req, en, ib, eb, wb, fl, 1'b0};
    endfunction

    task automatic modelAdvance(input logic r, input logic w, input logic rd, input logic l, input logic b);
        bit ms, ls;
        if (mErr) return;
        ms = ((mWait > 0) || r || w) && !rd;
        ls = !ms && !b && l;
        if (ms || ls) mCnt = mCnt + 32'd1;
        if (!ms) mWait = 0;
        else if (mWait == 0) mWait = 1;
        else if (mWait == TO) mErr = 1'b1;
        else mWait = (mWait < 255) ? mWait + 1 : 255;
    endtask

    task automatic step(input logic r, input logic w, input logic rd, input logic l, input logic b, output logic [10:0] got);
        @(negedge clk);
        rdEn = r; wrEn = w; rdy = rd; lu = l; br = b;
        #1;
        got = dutVec;
        cmp("outputs", {21'd0, got}, {21'd0, modelVec(r, w, rd, l, b)});
`ifdef STALL_PERF_COUNTER_EN
        cmp("stallCount", stallCount, mCnt);
`endif
        modelAdvance(r, w, rd, l, b);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must respond before any clock edge.
    task automatic doReset();
        @(negedge clk);
        rdEn = 1'b0; wrEn = 1'b0; rdy = 1'b0; lu = 1'b0; br = 1'b0;
        #2 rst = 1'b1;
        #1;
        mErr = 1'b0; mWait = 0; mCnt = 32'd0;
        cmp("reset_req", {31'd0, dmem_req}, 32'd0);
        cmp("reset_outputs", {21'd0, dutVec}, {21'd0, V_IDLE});
`ifdef STALL_PERF_COUNTER_EN
        cmp("reset_stallCount", stallCount, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : main
        logic [10:0] got;
        logic r, w, rd, l, b;

        #3 rst = 1'b1;
        #1;
        cmp("por_outputs", {21'd0, dutVec}, {21'd0, V_IDLE});
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait load
        step(1, 0, 1, 0, 0, got); cmp("load_zero_wait", {21'd0, got}, {21'd0, V_ACC});
        step(0, 0, 0, 0, 0, got); cmp("idle_after_load", {21'd0, got}, {21'd0, V_IDLE});

        // Store: 3 wait cycles, ready on the 4th
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, got); cmp("store_stall", {21'd0, got}, {21'd0, V_STALL});
        end
        step(0, 1, 1, 0, 0, got); cmp("store_done", {21'd0, got}, {21'd0, V_ACC});
        step(0, 0, 0, 0, 0, got); cmp("idle_after_store", {21'd0, got}, {21'd0, V_IDLE});

        // Branch beats load-use; load-use alone
        step(0, 0, 0, 1, 1, got); cmp("branch_over_loaduse", {21'd0, got}, {21'd0, V_BR});
        step(0, 0, 0, 1, 0, got); cmp("loaduse", {21'd0, got}, {21'd0, V_LU});
        // Memory stall overrides branch
        step(1, 0, 0, 1, 1, got); cmp("stall_over_branch", {21'd0, got}, {21'd0, V_STALL});
        step(0, 0, 1, 1, 1, got); cmp("wait_ready_branch", {21'd0, got}, {21'd0, V_ACC | V_BR});

        // Timeout: IDLE stall + TO wait cycles, then ERROR
        step(1, 0, 0, 0, 0, got);
        for (int i = 0; i < TO; i++) begin
            step(1, 0, 0, 0, 0, got); cmp("timeout_wait", {21'd0, got}, {21'd0, V_STALL});
        end
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 0, i == 1, 1, i == 2, got); cmp("error_hold", {21'd0, got}, {21'd0, V_ERR});
        end
        doReset();

        // Ready on the exact timeout cycle wins
        step(0, 1, 0, 0, 0, got);
        for (int i = 0; i < TO - 1; i++) step(0, 1, 0, 0, 0, got);
        step(0, 1, 1, 0, 0, got); cmp("ready_at_timeout", {21'd0, got}, {21'd0, V_ACC});
        step(0, 0, 0, 0, 0, got); cmp("no_error_after", {21'd0, got}, {21'd0, V_IDLE});

        // Stall tally: 2 load-use + 3 memory wait, then reset mid-WAIT
        doReset();
        step(0, 0, 0, 1, 0, got);
        step(0, 0, 0, 1, 0, got);
        step(1, 0, 0, 0, 0, got);
        step(1, 0, 0, 0, 0, got);
        step(1, 0, 0, 0, 0, got);
        step(1, 0, 1, 0, 0, got);
        step(0, 0, 0, 0, 0, got);
`ifdef STALL_PERF_COUNTER_EN
        cmp("stallCount_five", stallCount, 32'd5);
`endif
        step(0, 1, 0, 0, 0, got);
        step(0, 1, 0, 0, 0, got); cmp("mid_wait", {21'd0, got}, {21'd0, V_STALL});
        doReset();

        // Randomized run
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom % 4) == 0;
            w  = ($urandom % 5) == 0;
            rd = ($urandom % 3) != 0;
            l  = ($urandom % 5) == 0;
            b  = ($urandom % 6) == 0;
            step(r, w, rd, l, b, got);
            if (($urandom % 97) == 0 || (mErr && ($urandom % 6) == 0)) doReset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum WAIT cycles allowed before the error state is entered; legal range 1..255.
REQ-002 The block SHALL have exactly one clock and an asynchronous, active-high reset; the ports are clk and rst.
REQ-003 Ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- MEM_memReadEnable  in  1  load in MEM stage
- MEM_memWriteEnable  in  1  store in MEM stage
- dmem_ready  in  1  data memory completes the access this cycle
- loadUse_I  in  1  load-use stall request from hazard detection
- branch_I  in  1  taken branch/jump resolved in EX
- dmem_req  out  1  memory access request
- IF_pcWriteEnable, IF_ID_enable, ID_EX_enable, EX_MEM_enable, MEM_WB_enable  out  1 each  stage register enables
- ID_bubbleSelect, EX_bubbleSelect, WB_bubbleSelect  out  1 each  insert NOP into the stage
- IF_flush  out  1  squash the fetched instruction
- memError  out  1  sticky timeout flag
- stallCount  out  32  stall cycle count (present only when STALL_PERF_COUNTER_EN is defined)

Function
REQ-004 The FSM SHALL have three states: IDLE, WAIT, ERROR; it SHALL be a registered state machine with combinational outputs.
REQ-005 memAccess SHALL be defined as MEM_memReadEnable | MEM_memWriteEnable.
REQ-006 dmem_req SHALL be 1 when (IDLE & memAccess) or in WAIT; otherwise it SHALL be 0.
REQ-007 In IDLE with memAccess & dmem_ready, the access SHALL complete with zero wait; there SHALL be no stall and the state SHALL remain IDLE.
REQ-008 In IDLE with memAccess & !dmem_ready, the block SHALL assert memStall in the same cycle and SHALL transition to WAIT; the wait counter SHALL be loaded with 1.
REQ-009 In WAIT with !dmem_ready, memStall SHALL be 1 and the wait counter SHALL increment.
- When the counter equals MEM_TIMEOUT and dmem_ready is 0, the next state SHALL be ERROR.
REQ-010 In WAIT with dmem_ready, memStall SHALL be 0 that cycle and the next state SHALL be IDLE.
- dmem_ready in the same cycle the counter reaches MEM_TIMEOUT SHALL win: no error.
REQ-011 While memStall is 1, all five enables SHALL be 0 and WB_bubbleSelect SHALL be 1; IF_flush, ID_bubbleSelect and EX_bubbleSelect SHALL be 0; branch_I and loadUse_I SHALL be ignored.
REQ-012 If not memStall and branch_I: all enables SHALL be 1 and IF_flush = ID_bubbleSelect = EX_bubbleSelect = 1 (branch beats load-use).
REQ-013 If not memStall, not branch_I, and loadUse_I: IF_pcWriteEnable = IF_ID_enable = ID_EX_enable = 0, EX_MEM_enable = MEM_WB_enable = 1, and ID_bubbleSelect = 1.
REQ-014 With no condition active, all enables SHALL be 1 and all bubble/flush outputs SHALL be 0.
REQ-015 ERROR SHALL be absorbing until rst: all enables 0, dmem_req 0, memError 1, all bubble/flush outputs 0.
REQ-016 The wait counter SHALL be 8 bits wide and SHALL saturate; it SHALL be cleared on return to IDLE.

Reset
REQ-017 rst SHALL act asynchronously: state becomes IDLE, the wait counter 0, memError 0, and stallCount 0.
REQ-018 With no inputs active, outputs out of reset SHALL be: dmem_req 0, all enables 1, all bubble/flush outputs 0.
REQ-019 rst asserted mid-WAIT SHALL abandon the access immediately; dmem_req SHALL drop in the same cycle.

Configuration
REQ-020 When STALL_PERF_COUNTER_EN is defined, stallCount SHALL increment by 1 on every clock edge on which memStall or the load-use stall (REQ-013) was asserted; it SHALL wrap at 2^32 and SHALL not count in ERROR.
REQ-021 When STALL_PERF_COUNTER_EN is undefined, the stallCount port and its register SHALL be absent.

Verification
REQ-022 Load with dmem_ready=1 in the same cycle -> dmem_req=1, all enables 1, state stays IDLE.
REQ-023 Store with dmem_ready low for 3 cycles and high on the 4th -> enables 0 and WB_bubbleSelect 1 for 3 cycles, enables 1 on cycle 4, IDLE after.
REQ-024 branch_I=1 with loadUse_I=1 and no memory access -> IF_flush=ID_bubbleSelect=EX_bubbleSelect=1, all enables 1.
REQ-025 MEM_TIMEOUT=4 with dmem_ready never asserted -> ERROR after the 4th WAIT cycle, memError=1, dmem_req=0, held until rst; rst clears it asynchronously.
REQ-026 Macro defined, 2 load-use cycles + 3 memory-wait cycles -> stallCount=5; rst mid-WAIT -> stallCount=0 and dmem_req=0 immediately.
